// File: rtl/ov7670_sccb_init_seq.sv
// OV7670 SCCB init sequencer: walks a {reg,val} sync ROM and writes
// each entry through i2c_master's cmd/data AXI-stream host ports.
// Ports: start/active/done/error/err_index status, rom_addr/rom_data
// table fetch, s_axis_cmd_* and s_axis_data_* to i2c_master, busy and
// missed_ack from it, constant prescale/stop_on_idle/cmd_address.
// SCCB_VERIFY_EN: read each written register back and compare.
module ov7670_sccb_init_seq #(
  parameter logic [6:0]  DEV_ADDR = 7'h21,
  parameter int          DEPTH    = 64,
  parameter int          CLK_HZ   = 100_000_000,
  parameter logic [15:0] PRESCALE = 16'd63,
  parameter int          RETRIES  = 3,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic [6:0]    s_axis_cmd_address,
  output logic          s_axis_cmd_start,
  output logic          s_axis_cmd_read,
  output logic          s_axis_cmd_write,
  output logic          s_axis_cmd_write_multiple,
  output logic          s_axis_cmd_stop,
  output logic          s_axis_cmd_valid,
  input  logic          s_axis_cmd_ready,
  output logic [7:0]    s_axis_data_tdata,
  output logic          s_axis_data_tvalid,
  output logic          s_axis_data_tlast,
  input  logic          s_axis_data_tready,
  input  logic [7:0]    m_axis_data_tdata,
  input  logic          m_axis_data_tvalid,
  output logic          m_axis_data_tready,
  input  logic          busy,
  input  logic          missed_ack,
  output logic [15:0]   prescale,
  output logic          stop_on_idle,
  output logic          active,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_index
);

  localparam int MS = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int CW = (MS > 1) ? $clog2(MS) : 1;
  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_CMD,
    S_D0,
    S_D1,
    S_WAIT,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERR
`ifdef SCCB_VERIFY_EN
    ,
    S_VCMD,
    S_VD,
    S_VWAIT,
    S_RCMD,
    S_RDATA,
    S_RWAIT
`endif
  } state_t;

  state_t        state;
  logic [7:0]    reg_q;
  logic [7:0]    val_q;
  logic [7:0]    ms_left;
  logic [CW-1:0] cyc;
  logic [RW-1:0] retry_cnt;
  logic          nack;

  logic cmd_hs;
  logic dat_hs;
  logic fail_now;
  logic can_retry;
  logic at_end;

  assign s_axis_cmd_address = DEV_ADDR;
  assign prescale           = PRESCALE;
  assign stop_on_idle       = 1'b0;

  assign cmd_hs    = s_axis_cmd_valid && s_axis_cmd_ready;
  assign dat_hs    = s_axis_data_tvalid && s_axis_data_tready;
  assign can_retry = retry_cnt < RW'(RETRIES);
  assign at_end    = rom_addr == AW'(DEPTH - 1);

`ifdef SCCB_VERIFY_EN
  logic mismatch;

  assign fail_now = nack || missed_ack ||
                    (state == S_RWAIT && mismatch);
`else
  logic unused_m_axis;

  assign unused_m_axis = &{1'b0, m_axis_data_tdata,
                           m_axis_data_tvalid};
  assign fail_now = nack || missed_ack;
  assign m_axis_data_tready = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state                     <= S_IDLE;
      rom_addr                  <= '0;
      err_index                 <= '0;
      retry_cnt                 <= '0;
      s_axis_cmd_start          <= 1'b0;
      s_axis_cmd_read           <= 1'b0;
      s_axis_cmd_write          <= 1'b0;
      s_axis_cmd_write_multiple <= 1'b0;
      s_axis_cmd_stop           <= 1'b0;
      s_axis_cmd_valid          <= 1'b0;
      s_axis_data_tdata         <= 8'h00;
      s_axis_data_tvalid        <= 1'b0;
      s_axis_data_tlast         <= 1'b0;
      active                    <= 1'b0;
      done                      <= 1'b0;
      error                     <= 1'b0;
      reg_q                     <= 8'h00;
      val_q                     <= 8'h00;
      ms_left                   <= 8'h00;
      cyc                       <= '0;
      nack                      <= 1'b0;
`ifdef SCCB_VERIFY_EN
      m_axis_data_tready        <= 1'b0;
      mismatch                  <= 1'b0;
`endif
    end else begin
      // sticky NACK for the current entry; cleared on each CMD load
      if (missed_ack && active) nack <= 1'b1;

      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            rom_addr  <= '0;
            retry_cnt <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            active    <= 1'b1;
            state     <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          reg_q <= rom_data[15:8];
          val_q <= rom_data[7:0];
          if (rom_data == 16'hFFFF) begin
            done   <= 1'b1;
            active <= 1'b0;
            state  <= S_DONE;
          end else if (rom_data[15:8] == 8'hFF) begin
            ms_left <= rom_data[7:0];
            cyc     <= '0;
            state   <= (rom_data[7:0] == 8'h00) ? S_NEXT : S_DELAY;
          end else begin
            s_axis_cmd_start          <= 1'b1;
            s_axis_cmd_read           <= 1'b0;
            s_axis_cmd_write          <= 1'b0;
            s_axis_cmd_write_multiple <= 1'b1;
            s_axis_cmd_stop           <= 1'b1;
            s_axis_cmd_valid          <= 1'b1;
            nack                      <= 1'b0;
            state                     <= S_CMD;
          end
        end

        S_CMD: begin
          if (cmd_hs) begin
            s_axis_cmd_valid          <= 1'b0;
            s_axis_cmd_start          <= 1'b0;
            s_axis_cmd_write_multiple <= 1'b0;
            s_axis_cmd_stop           <= 1'b0;
            s_axis_data_tdata         <= reg_q;
            s_axis_data_tlast         <= 1'b0;
            s_axis_data_tvalid        <= 1'b1;
            state                     <= S_D0;
          end
        end

        S_D0: begin
          if (dat_hs) begin
            s_axis_data_tdata <= val_q;
            s_axis_data_tlast <= 1'b1;
            state             <= S_D1;
          end
        end

        S_D1: begin
          if (dat_hs) begin
            s_axis_data_tvalid <= 1'b0;
            s_axis_data_tlast  <= 1'b0;
            state              <= S_WAIT;
          end
        end

        S_WAIT
`ifdef SCCB_VERIFY_EN
        , S_VWAIT, S_RWAIT
`endif
        : begin
          if (!busy) begin
            if (fail_now && can_retry) begin
              retry_cnt                 <= retry_cnt + 1'b1;
              s_axis_cmd_start          <= 1'b1;
              s_axis_cmd_read           <= 1'b0;
              s_axis_cmd_write          <= 1'b0;
              s_axis_cmd_write_multiple <= 1'b1;
              s_axis_cmd_stop           <= 1'b1;
              s_axis_cmd_valid          <= 1'b1;
              nack                      <= 1'b0;
              state                     <= S_CMD;
            end else if (fail_now) begin
              err_index <= rom_addr;
              error     <= 1'b1;
              active    <= 1'b0;
              state     <= S_ERR;
`ifdef SCCB_VERIFY_EN
            end else if (state == S_WAIT && reg_q != 8'h12) begin
              // COM7 soft-resets the sensor, so it cannot be read back
              s_axis_cmd_start <= 1'b1;
              s_axis_cmd_write <= 1'b1;
              s_axis_cmd_stop  <= 1'b1;
              s_axis_cmd_valid <= 1'b1;
              state            <= S_VCMD;
            end else if (state == S_VWAIT) begin
              s_axis_cmd_start <= 1'b1;
              s_axis_cmd_read  <= 1'b1;
              s_axis_cmd_stop  <= 1'b1;
              s_axis_cmd_valid <= 1'b1;
              state            <= S_RCMD;
`endif
            end else begin
              retry_cnt <= '0;
              state     <= S_NEXT;
            end
          end
        end

        S_DELAY: begin
          if (cyc == CW'(MS - 1)) begin
            cyc <= '0;
            if (ms_left == 8'd1) state <= S_NEXT;
            else ms_left <= ms_left - 8'd1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end

        S_NEXT: begin
          // no wrap: running off the table counts as the end marker
          if (at_end) begin
            done   <= 1'b1;
            active <= 1'b0;
            state  <= S_DONE;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= S_FETCH;
          end
        end

`ifdef SCCB_VERIFY_EN
        S_VCMD: begin
          if (cmd_hs) begin
            s_axis_cmd_valid   <= 1'b0;
            s_axis_cmd_start   <= 1'b0;
            s_axis_cmd_write   <= 1'b0;
            s_axis_cmd_stop    <= 1'b0;
            s_axis_data_tdata  <= reg_q;
            s_axis_data_tlast  <= 1'b1;
            s_axis_data_tvalid <= 1'b1;
            state              <= S_VD;
          end
        end

        S_VD: begin
          if (dat_hs) begin
            s_axis_data_tvalid <= 1'b0;
            s_axis_data_tlast  <= 1'b0;
            state              <= S_VWAIT;
          end
        end

        S_RCMD: begin
          if (cmd_hs) begin
            s_axis_cmd_valid   <= 1'b0;
            s_axis_cmd_start   <= 1'b0;
            s_axis_cmd_read    <= 1'b0;
            s_axis_cmd_stop    <= 1'b0;
            m_axis_data_tready <= 1'b1;
            mismatch           <= 1'b0;
            state              <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (m_axis_data_tvalid) begin
            m_axis_data_tready <= 1'b0;
            mismatch           <= m_axis_data_tdata != val_q;
            state              <= S_RWAIT;
          end else if (!busy) begin
            // transfer ended with no byte: treat as a failed readback
            m_axis_data_tready <= 1'b0;
            mismatch           <= 1'b1;
            state              <= S_RWAIT;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
